adc_capture_streamer: RTL and testbench

Parametrised ADC capture engine: samples the parallel ADC bus on a programmable sample tick, buffers samples in a FIFO, and streams them as bytes to the UART transmitter over a valid/ready handshake. Two modes are supported: free-run, a continuous sample stream, and triggered single-shot, where a rising-edge level trigger starts a header-framed block of DEPTH samples. It sits between the `adcIn` pins and the UART TX adapter in `top`, replacing the fixed-pattern periodic transmit.

---
 rtl/scope_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 54 +++++
 rtl/adc_capture_streamer.sv | 159 +++++++++++++++
 tb/tb_adc_capture_streamer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared constants and state encoding for the ADC capture streamer
package scope_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STREAM    = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_SEND_HDR  = 3'd4;
  localparam logic [2:0] S_SEND_DATA = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_STREAM    = S_STREAM,
    ST_ARMED     = S_ARMED,
    ST_CAPTURE   = S_CAPTURE,
    ST_SEND_HDR  = S_SEND_HDR,
    ST_SEND_DATA = S_SEND_DATA
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO holding captured ADC samples
// Ports: clk, rst (sync, active-high); push/push_data write side; pop/pop_data
// read side (pop_data shows the head entry combinationally); full, empty, count.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_capture_streamer.sv
// rtl/adc_capture_streamer.sv - ADC sampler with free-run and triggered block streaming to UART TX
// Ports: clk, rst (sync, active-high); adc_in sample bus; mode (0 free-run,
// 1 triggered); trig_level threshold; arm pulse; tx_data/tx_valid/tx_ready byte
// stream; busy (not idle), triggered (block in flight), overflow (sticky drop).
module adc_capture_streamer
  import scope_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter int         SAMPLE_DIV = 3744,
  parameter int         DEPTH      = 256,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              arm,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              triggered,
  output logic              overflow
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);

  state_t            state, state_nx;
  logic [CW-1:0]     tick_cnt;
  logic              tick;
  logic [DATA_W-1:0] prev;
  logic [AW:0]       sent_cnt;
  logic              hdr_loaded;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [AW:0]       fifo_count;
  logic              out_free, accept, hit, stage_full, last_accept;
  logic [AW+1:0]     stored;

  sample_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (adc_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tick     = (tick_cnt == CW'(SAMPLE_DIV - 1));
  assign out_free = !tx_valid || tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign hit      = tick && (prev < trig_level) && (adc_in >= trig_level);
  assign busy     = (state != ST_IDLE);
  // In free-run the output register counts against capacity, so exactly DEPTH
  // samples are buffered before one is dropped.
  assign stored      = {1'b0, fifo_count} + {{(AW+1){1'b0}}, tx_valid};
  assign stage_full  = (stored >= CAP);
  assign last_accept = (state == ST_SEND_DATA) && accept && (sent_cnt == (AW+1)'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_FREE) state_nx = ST_STREAM;
        else if (arm)          state_nx = ST_ARMED;
      end
      ST_STREAM: begin
        fifo_pop = out_free && !fifo_empty;
        if (mode == MODE_TRIG) begin
          if (fifo_empty) state_nx = ST_IDLE;
        end else begin
          fifo_push = tick && (!stage_full || accept);
        end
      end
      ST_ARMED: begin
        if (hit) begin
          fifo_push = 1'b1;
          state_nx  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (fifo_full) state_nx = ST_SEND_HDR;
        else           fifo_push = tick;
      end
      ST_SEND_HDR: begin
        if (hdr_loaded && accept) state_nx = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        fifo_pop = out_free && !fifo_empty;
        if (last_accept) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      hdr_loaded <= 1'b0;
      sent_cnt   <= '0;
      prev       <= '0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        tx_valid <= 1'b1;
        tx_data  <= 8'(fifo_dout);
      end else if (state == ST_SEND_HDR && !hdr_loaded && out_free) begin
        tx_valid <= 1'b1;
        tx_data  <= HEADER;
      end else if (accept) begin
        tx_valid <= 1'b0;
      end

      if (state == ST_SEND_HDR) begin
        if (out_free) hdr_loaded <= 1'b1;
      end else begin
        hdr_loaded <= 1'b0;
      end

      if (state != ST_SEND_DATA) sent_cnt <= '0;
      else if (accept)           sent_cnt <= sent_cnt + 1'b1;

      // Seeding with the threshold means a signal already at or above it must
      // first dip below before it can trigger.
      if (state == ST_IDLE && state_nx == ST_ARMED) prev <= trig_level;
      else if (state == ST_ARMED && tick)           prev <= adc_in;

      if (state == ST_ARMED && hit) triggered <= 1'b1;
      else if (last_accept)         triggered <= 1'b0;

      if (state == ST_IDLE && state_nx == ST_STREAM) begin
        overflow <= 1'b0;
      end else if (state == ST_STREAM && mode == MODE_FREE && tick && stage_full && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_streamer.sv
// tb/tb_adc_capture_streamer.sv - directed self-checking bench for adc_capture_streamer
module tb_adc_capture_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_in;
  logic       mode;
  logic [7:0] trig_level;
  logic       arm;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       triggered;
  logic       overflow;

  int n_pass = 0;
  int n_total = 0;
  int ph = 0;
  logic [7:0] got [$];
  logic       got_trig [$];

  always #5 clk = ~clk;

  adc_capture_streamer #(
    .DATA_W(8), .SAMPLE_DIV(4), .DEPTH(4), .HEADER(8'hAA)
  ) dut (
    .clk(clk), .rst(rst), .adc_in(adc_in), .mode(mode), .trig_level(trig_level),
    .arm(arm), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .triggered(triggered), .overflow(overflow)
  );

  // Expected sample-tick phase: tick is high in cycles where ph == 3.
  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= (ph == 3) ? 0 : ph + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    arm = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // Present v for the next sample tick and return just after that tick's edge.
  task automatic feed(input logic [7:0] v);
    int n = 0;
    adc_in = v;
    while (ph != 3 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (ph != 3) begin
      n_total++;
      $display("FAIL tick_wait: phase %0d, required 3", ph);
    end
    @(posedge clk); #1;
  endtask

  // Record transferred bytes; returns with the n-th transfer still pending its edge.
  task automatic collect(input int n, input int budget);
    got.delete();
    got_trig.delete();
    for (int c = 0; c < budget; c++) begin
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        got_trig.push_back(triggered);
      end
      if (got.size() >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    mode = 1'b1; tx_ready = 1'b0; adc_in = 8'h00; trig_level = 8'h80;
    do_reset();
    n_total++;
    if ({tx_valid, tx_data, busy, triggered, overflow} !== 12'h000)
      $display("FAIL reset_outputs: got %h, required 000", {tx_valid, tx_data, busy, triggered, overflow});
    else n_pass++;
  endtask

  task automatic test_free_run();
    mode = 1'b0; tx_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = 8'h10 + 8'(i);
      feed(v);
      n_total++;
      if (tx_valid !== 1'b0) $display("FAIL free_lat1[%0d]: tx_valid %b, required 0", i, tx_valid);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== v)
        $display("FAIL free_lat2[%0d]: valid %b data %h, required 1 %h", i, tx_valid, tx_data, v);
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b0) $display("FAIL free_overflow: %b, required 0", overflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int extra = 0;
    mode = 1'b0; tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed(8'h20 + 8'(i));
      if (i == 3) begin
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_tick4: %b, required 0", overflow);
        else n_pass++;
      end
    end
    n_total++;
    if (overflow !== 1'b1) $display("FAIL ovf_tick5: %b, required 1", overflow);
    else n_pass++;
    repeat (20) @(posedge clk);
    #1;
    mode = 1'b1; tx_ready = 1'b1;
    collect(4, 30);
    n_total++;
    if (got.size() != 4 || got[0] !== 8'h20 || got[1] !== 8'h21 || got[2] !== 8'h22 || got[3] !== 8'h23)
      $display("FAIL ovf_bytes: got %p, required 20 21 22 23", got);
    else n_pass++;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      if (tx_valid) extra++;
      @(posedge clk); #1;
    end
    n_total++;
    if (extra != 0 || busy !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf_after: extra %0d busy %b overflow %b, required 0 0 1", extra, busy, overflow);
    else n_pass++;
  endtask

  task automatic test_triggered();
    logic [7:0] exp [5] = '{8'hAA, 8'h80, 8'h90, 8'hA0, 8'hB0};
    mode = 1'b1; tx_ready = 1'b1; trig_level = 8'h80;
    do_reset();
    do_arm();
    feed(8'h70);
    feed(8'h7F);
    n_total++;
    if (triggered !== 1'b0) $display("FAIL trig_early: %b, required 0", triggered);
    else n_pass++;
    feed(8'h80);
    n_total++;
    if (triggered !== 1'b1) $display("FAIL trig_hit: %b, required 1", triggered);
    else n_pass++;
    feed(8'h90);
    feed(8'hA0);
    feed(8'hB0);
    collect(5, 40);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== exp[i] || got_trig[i] !== 1'b1)
        $display("FAIL trig_byte[%0d]: got %p, required %h with triggered 1", i, got, exp[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || triggered !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL trig_end: busy %b trig %b valid %b, required 0 0 0", busy, triggered, tx_valid);
    else n_pass++;
  endtask

  task automatic test_no_false_trigger();
    logic [7:0] exp [5] = '{8'hAA, 8'h90, 8'h91, 8'h92, 8'h93};
    mode = 1'b1; tx_ready = 1'b1; trig_level = 8'h80; adc_in = 8'hFF;
    do_reset();
    do_arm();
    for (int i = 0; i < 4; i++) feed(8'hFF);
    n_total++;
    if (triggered !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL high_hold: trig %b valid %b busy %b, required 0 0 1", triggered, tx_valid, busy);
    else n_pass++;
    feed(8'h00);
    n_total++;
    if (triggered !== 1'b0) $display("FAIL low_tick: %b, required 0", triggered);
    else n_pass++;
    feed(8'h90);
    n_total++;
    if (triggered !== 1'b1) $display("FAIL rise_tick: %b, required 1", triggered);
    else n_pass++;
    feed(8'h91);
    feed(8'h92);
    feed(8'h93);
    collect(5, 40);
    n_total++;
    if (got.size() != 5 || got[0] !== exp[0] || got[1] !== exp[1] || got[2] !== exp[2] ||
        got[3] !== exp[3] || got[4] !== exp[4])
      $display("FAIL rise_frame: got %p, required AA 90 91 92 93", got);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    logic       pv, pr;
    logic [7:0] pd;
    mode = 1'b1; tx_ready = 1'b0; trig_level = 8'h80;
    do_reset();
    do_arm();
    feed(8'h00);
    feed(8'h81);
    feed(8'h82);
    feed(8'h83);
    feed(8'h84);
    got.delete();
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    for (int c = 0; c < 400 && got.size() < 5; c++) begin
      @(posedge clk); #1;
      if (pv && !pr) begin
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== pd)
          $display("FAIL stall_hold: valid %b data %h, required 1 %h", tx_valid, tx_data, pd);
        else n_pass++;
      end
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) got.push_back(tx_data);
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    n_total++;
    if (got.size() != 5 || got[0] !== 8'hAA || got[1] !== 8'h81 || got[2] !== 8'h82 ||
        got[3] !== 8'h83 || got[4] !== 8'h84 || busy !== 1'b0)
      $display("FAIL bp_frame: got %p busy %b, required AA 81 82 83 84 busy 0", got, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    mode = 1'b1; tx_ready = 1'b1; trig_level = 8'h80;
    do_reset();
    do_arm();
    feed(8'h00);
    feed(8'h85);
    feed(8'h86);
    feed(8'h87);
    feed(8'h88);
    collect(2, 40);
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1 || tx_valid !== 1'b1)
      $display("FAIL mid_send: busy %b valid %b, required 1 1", busy, tx_valid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({tx_valid, tx_data, busy, triggered, overflow} !== 12'h000)
      $display("FAIL mid_reset: got %h, required 000", {tx_valid, tx_data, busy, triggered, overflow});
    else n_pass++;
    rst = 1'b0;
    do_arm();
    feed(8'h00);
    feed(8'h95);
    feed(8'h96);
    feed(8'h97);
    feed(8'h98);
    collect(5, 40);
    n_total++;
    if (got.size() != 5 || got[0] !== 8'hAA || got[1] !== 8'h95 || got[4] !== 8'h98)
      $display("FAIL rearm_frame: got %p, required AA 95 96 97 98", got);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; mode = 1'b1; tx_ready = 1'b0; adc_in = 8'h00; trig_level = 8'h80;
    test_reset();
    test_free_run();
    test_overflow();
    test_triggered();
    test_no_false_trigger();
    test_back_pressure();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
